alu_exec_unit: RTL and testbench

//  Execute-stage ALU that consumes the 3-bit ALUControl code from the ALU decoder plus two operands.

---
 rtl/alu_exec_unit.sv | 156 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes; SLL/SRA iterate one bit per cycle.
// Define ALU_FLAGS_EN to add the registered negative/carry/overflow outputs.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             negative,
  output logic             carry,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_NOT = 3'b010, OP_SLL = 3'b011,
    OP_SRA = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_SLT = 3'b111
  } alu_op_t;

  state_t             state_q, state_d;
  alu_op_t            op;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               is_shift;
  logic               start_shift;

  logic [WIDTH-1:0]   add_res, sub_res, alu_res;
  logic               sub_ovf, slt_lt;

  logic [WIDTH-1:0]   work_q, shift_next;
  logic [SHAMT_W-1:0] cnt_q;
  logic               sra_q;
  logic               shift_last;

  assign op          = alu_op_t'(alu_control);
  assign shamt       = src_b[SHAMT_W-1:0];
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid & in_ready;
  assign is_shift    = (op == OP_SLL) || (op == OP_SRA);
  assign start_shift = is_shift && (shamt != '0);
  assign shift_last  = (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1});

`ifdef ALU_FLAGS_EN
  logic add_c, sub_c, add_ovf, alu_carry, alu_ovf;
  assign {add_c, add_res} = {1'b0, src_a} + {1'b0, src_b};
  assign {sub_c, sub_res} = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_res[WIDTH-1] != src_a[WIDTH-1]);
  assign alu_carry = (op == OP_ADD) ? add_c :
                     ((op == OP_SUB) || (op == OP_SLT)) ? sub_c : 1'b0;
  assign alu_ovf   = (op == OP_ADD) ? add_ovf :
                     ((op == OP_SUB) || (op == OP_SLT)) ? sub_ovf : 1'b0;
`else
  assign add_res = src_a + src_b;
  assign sub_res = src_a + ~src_b + {{(WIDTH-1){1'b0}}, 1'b1};
`endif

  // Signed less-than comes from the sign of A-B corrected by its overflow.
  assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_res[WIDTH-1] != src_a[WIDTH-1]);
  assign slt_lt  = sub_res[WIDTH-1] ^ sub_ovf;

  always_comb begin
    alu_res = add_res;
    case (op)
      OP_ADD:         alu_res = add_res;
      OP_SUB:         alu_res = sub_res;
      OP_NOT:         alu_res = ~src_a;
      OP_SLL, OP_SRA: alu_res = src_a;
      OP_AND:         alu_res = src_a & src_b;
      OP_OR:          alu_res = src_a | src_b;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      default:        alu_res = add_res;
    endcase
  end

  assign shift_next = sra_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]}
                            : {work_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (shift_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers only change when an operation completes, so DONE holds them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q   <= '0;
      cnt_q    <= '0;
      sra_q    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
`ifdef ALU_FLAGS_EN
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              work_q <= src_a;
              cnt_q  <= shamt;
              sra_q  <= (op == OP_SRA);
            end else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
`ifdef ALU_FLAGS_EN
              negative <= alu_res[WIDTH-1];
              carry    <= alu_carry;
              overflow <= alu_ovf;
`endif
            end
          end
        end
        SHIFT: begin
          work_q <= shift_next;
          cnt_q  <= cnt_q - 1'b1;
          if (shift_last) begin
            result   <= shift_next;
            zero     <= (shift_next == '0);
`ifdef ALU_FLAGS_EN
            negative <= shift_next[WIDTH-1];
            carry    <= 1'b0;
            overflow <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed and random ops against a behavioural model.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
`ifdef ALU_FLAGS_EN
  logic        negative, carry, overflow;
  logic [2:0]  obs_flags;
`endif

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
`ifdef ALU_FLAGS_EN
    , .negative(negative), .carry(carry), .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model straight from the arithmetic definitions.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sa;
    sh = int'(b[4:0]);
    sa = a;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~a;
      3'd3: return a << sh;
      3'd4: begin sa = sa >>> sh; return sa; end
      3'd5: return a & b;
      3'd6: return a | b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] b);
    if ((op == 3'd3 || op == 3'd4) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

`ifdef ALU_FLAGS_EN
  function automatic logic [2:0] model_flags(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub;
    longint s;
    logic [31:0] r;
    logic c, v;
    ua = 64'(a);
    ub = 64'(b);
    r = model_result(op, a, b);
    c = 1'b0;
    v = 1'b0;
    if (op == 3'd0) begin
      c = (ua + ub) > 64'hFFFF_FFFF;
      s = longint'($signed(a)) + longint'($signed(b));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op == 3'd1 || op == 3'd7) begin
      c = (a >= b);
      s = longint'($signed(a)) - longint'($signed(b));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r[31], c, v};
  endfunction
`endif

  // Offers one op from IDLE, scrambles the inputs after accept, and waits (bounded) for out_valid.
  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic got_valid, output logic [31:0] res, output logic z, output int lat);
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; alu_control = 3'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    got_valid = out_valid;
    res = result;
    z = zero;
`ifdef ALU_FLAGS_EN
    obs_flags = {negative, carry, overflow};
`endif
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 3'd0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result got=%h want=0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero got=%b want=0", zero); end
  endtask

  // Shared body for directed and random op lists.
  task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic v, z;
    logic [31:0] r, er;
    int lat, el;
    er = model_result(op, a, b);
    el = model_latency(op, b);
    issue_op(op, a, b, v, r, z, lat);
    checks++; if (v !== 1'b1) begin errors++; $display("[TB] FAIL %s_valid op=%0d got=%b want=1", tag, op, v); end
    checks++; if (lat != el) begin errors++; $display("[TB] FAIL %s_latency op=%0d a=%h b=%h got=%0d want=%0d", tag, op, a, b, lat, el); end
    checks++; if (r !== er) begin errors++; $display("[TB] FAIL %s_result op=%0d a=%h b=%h got=%h want=%h", tag, op, a, b, r, er); end
    checks++; if (z !== (er == 32'd0)) begin errors++; $display("[TB] FAIL %s_zero op=%0d got=%b want=%b", tag, op, z, (er == 32'd0)); end
`ifdef ALU_FLAGS_EN
    checks++; if (obs_flags !== model_flags(op, a, b)) begin errors++; $display("[TB] FAIL %s_flags op=%0d a=%h b=%h got=%b want=%b", tag, op, a, b, obs_flags, model_flags(op, a, b)); end
`endif
    consume();
  endtask

  task automatic test_arith();
    logic [2:0]  ops [9] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd7, 3'd7, 3'd5, 3'd6, 3'd1};
    logic [31:0] as  [9] = '{32'h7FFFFFFF, 32'h5, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h80000000,
                             32'h1, 32'hF0F0_1234, 32'h0000_00F0, 32'h1};
    logic [31:0] bs  [9] = '{32'h1, 32'h5, 32'hDEADBEEF, 32'h1, 32'h7FFFFFFF,
                             32'hFFFFFFFF, 32'h0FF0_FF00, 32'h0F00_000F, 32'h2};
    for (int i = 0; i < 9; i++) run_and_check("arith", ops[i], as[i], bs[i]);
  endtask

  task automatic test_shift();
    logic [2:0]  ops [5] = '{3'd3, 3'd4, 3'd4, 3'd3, 3'd4};
    logic [31:0] as  [5] = '{32'h1, 32'h80000000, 32'h12345678, 32'h1, 32'h4000_0000};
    logic [31:0] bs  [5] = '{32'd31, 32'd4, 32'd0, 32'h21, 32'd31};
    for (int i = 0; i < 5; i++) run_and_check("shift", ops[i], as[i], bs[i]);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_and_check("random", op, a, b);
    end
  endtask

  task automatic test_backpressure();
    logic v, z;
    logic [31:0] r, er, er2;
    int lat;
    er = model_result(3'd0, 32'h1234_0000, 32'h0000_5678);
    er2 = model_result(3'd6, 32'hA000_0000, 32'h0000_000B);
    issue_op(3'd0, 32'h1234_0000, 32'h0000_5678, v, r, z, lat);
    in_valid = 1'b1; alu_control = 3'd6; src_a = 32'hA000_0000; src_b = 32'h0000_000B;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || result !== er || zero !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold cyc=%0d valid=%b result=%h zero=%b want 1/%h/0", i, out_valid, result, zero, er); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== er2) begin errors++; $display("[TB] FAIL bp_held_op valid=%b result=%h want 1/%h", out_valid, result, er2); end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    logic v, z, stale;
    logic [31:0] r;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'd3; src_a = 32'h0000_0ABC; src_b = 32'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_state out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (result !== 32'd0 || zero !== 1'b0) begin errors++; $display("[TB] FAIL abort_result result=%h zero=%b want 0/0", result, zero); end
    stale = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL abort_stale got=%b want=0", stale); end
    issue_op(3'd0, 32'd3, 32'd4, v, r, z, lat);
    checks++; if (v !== 1'b1 || r !== 32'd7) begin errors++; $display("[TB] FAIL abort_recover valid=%b result=%h want 1/00000007", v, r); end
    consume();
  endtask

  // out_ready and in_valid held high: each op takes exactly two cycles.
  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b, er;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle i=%0d in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid); end
      do op = 3'($urandom_range(0, 7)); while (op == 3'd3 || op == 3'd4);
      a = $urandom; b = $urandom;
      er = model_result(op, a, b);
      in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || result !== er) begin errors++; $display("[TB] FAIL b2b_result i=%0d op=%0d valid=%b got=%h want=%h", i, op, out_valid, result, er); end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
